// File: rtl/sha256_sequencer_if.sv
// sha256_sequencer_if: message-store read port and compression-core strobes
// driven by the SHA-256 sequencer.
interface sha256_sequencer_if #(
    parameter int AW = 6
);
    logic          msg_rd_en;
    logic [AW-1:0] msg_rd_addr;
    logic [31:0]   msg_rd_data;
    logic          core_init;
    logic          core_round_en;
    logic [5:0]    core_round;
    logic [31:0]   core_wt;
    logic          core_update;

    modport master (
        output msg_rd_en, msg_rd_addr, core_init, core_round_en, core_round, core_wt, core_update,
        input  msg_rd_data
    );

    modport slave (
        input  msg_rd_en, msg_rd_addr, core_init, core_round_en, core_round, core_wt, core_update,
        output msg_rd_data
    );
endinterface

// File: rtl/sha256_sequencer.sv
// sha256_sequencer: fetches 512-bit blocks, expands the message schedule in a
// 16-word circular buffer and strobes the SHA-256 compression core.
module sha256_sequencer #(
    parameter int MAX_BLOCKS = 4,
    parameter int AW         = $clog2(MAX_BLOCKS*16),
    parameter int NBW        = $clog2(MAX_BLOCKS+1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [NBW-1:0] nblocks,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    sha256_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD, INIT, ROUND, UPDATE, DONE} state_t;

    state_t         state_q, state_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [NBW-1:0] blk_q, blk_d, nblk_q, nblk_d;
    logic           rd_en_q, rd_en_d;
    logic [AW-1:0]  rd_addr_q, rd_addr_d;
    logic           init_q, init_d, round_en_q, round_en_d, update_q, update_d;
    logic [5:0]     round_q, round_d;
    logic [31:0]    wt_q, wt_d;
    logic           busy_q, busy_d, done_q, done_d;
    logic [31:0]    w_q [16];
    logic [31:0]    w_d [16];
    logic [3:0]     n;
    logic [31:0]    w_next;

    function automatic logic [31:0] s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        nblk_d  = nblk_q;
        case (state_q)
            IDLE: if (start && nblocks != '0) begin
                state_d = LOAD;
                cnt_d   = '0;
                blk_d   = '0;
                nblk_d  = nblocks > NBW'(MAX_BLOCKS) ? NBW'(MAX_BLOCKS) : nblocks;
            end
            LOAD: begin
                cnt_d   = cnt_q == 6'd16 ? '0 : cnt_q + 6'd1;
                state_d = cnt_q == 6'd16 ? INIT : LOAD;
            end
            INIT: begin
                state_d = ROUND;
                cnt_d   = '0;
            end
            ROUND: begin
                cnt_d   = cnt_q + 6'd1;
                state_d = cnt_q == 6'd63 ? UPDATE : ROUND;
            end
            UPDATE: begin
                blk_d   = blk_q + NBW'(1);
                cnt_d   = '0;
                state_d = blk_d < nblk_q ? LOAD : DONE;
            end
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Outputs are registered from the next state, so W_t is formed one cycle
    // ahead from words already in the buffer (W_{t-2} was written last cycle).
    always_comb begin
        n          = cnt_d[3:0];
        w_next     = cnt_d < 6'd16 ? w_q[n]
                   : s1(w_q[n - 4'd2]) + w_q[n - 4'd7] + s0(w_q[n - 4'd15]) + w_q[n];
        rd_en_d    = state_d == LOAD && cnt_d < 6'd16;
        rd_addr_d  = rd_en_d ? AW'({blk_d, n}) : '0;
        init_d     = state_d == INIT;
        round_en_d = state_d == ROUND;
        round_d    = round_en_d ? cnt_d : '0;
        wt_d       = round_en_d ? w_next : '0;
        update_d   = state_d == UPDATE;
        done_d     = state_d == DONE;
        busy_d     = state_d != IDLE;
        w_d        = w_q;
        if (state_q == LOAD && cnt_q != '0) w_d[cnt_q[3:0] - 4'd1] = bus.msg_rd_data;
        if (state_q == ROUND && cnt_q >= 6'd16) w_d[cnt_q[3:0]] = wt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            blk_q      <= '0;
            nblk_q     <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            init_q     <= 1'b0;
            round_en_q <= 1'b0;
            round_q    <= '0;
            wt_q       <= '0;
            update_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            blk_q      <= blk_d;
            nblk_q     <= nblk_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            init_q     <= init_d;
            round_en_q <= round_en_d;
            round_q    <= round_d;
            wt_q       <= wt_d;
            update_q   <= update_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        w_q <= w_d;
    end

    assign bus.msg_rd_en     = rd_en_q;
    assign bus.msg_rd_addr   = rd_addr_q;
    assign bus.core_init     = init_q;
    assign bus.core_round_en = round_en_q;
    assign bus.core_round    = round_q;
    assign bus.core_wt       = wt_q;
    assign bus.core_update   = update_q;
    assign busy              = busy_q;
    assign done              = done_q;
endmodule

// File: tb/tb_sha256_sequencer.sv
// tb_sha256_sequencer: table-driven bench with a message-store model and a
// reference SHA-256 compression core fed by the sequencer strobes.
module tb_sha256_sequencer;
    localparam int MAXB = 4;
    localparam int AW   = 6;
    localparam int NBW  = 3;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [NBW-1:0] nblocks = '0;
    logic busy, done;

    sha256_sequencer_if #(.AW(AW)) bus();

    sha256_sequencer #(.MAX_BLOCKS(MAXB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .nblocks(nblocks), .abort(abort),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   nb;
        int           msel;
        bit           spam;
        int           exp_upd;
        int           exp_done;
        int           exp_rd;
        bit           chk_dig;
        logic [255:0] dig;
    } vec_t;

    vec_t vt [6];
    int errors = 0, checks = 0;
    int cyc, n_upd, n_done, done_cyc, n_rd, rd_bad, upd_bad, busy_cnt, viol;
    logic [31:0] wt16, wt17;
    logic prev_en = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [31:0] mem [64];
    logic [31:0] hh [8];
    logic [31:0] v [8];

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_v(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
        return (x >> s) | (x << (32 - s));
    endfunction

    function automatic logic [255:0] outs();
        return 256'({busy, done, bus.msg_rd_en, bus.msg_rd_addr, bus.core_init, bus.core_round_en,
                     bus.core_round, bus.core_wt, bus.core_update});
    endfunction

    task automatic core_step();
        logic [31:0] t1, t2;
        if (bus.core_init) v = hh;
        if (bus.core_round_en) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
               + K[bus.core_round] + bus.core_wt;
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        if (bus.core_update) for (int i = 0; i < 8; i++) hh[i] = hh[i] + v[i];
    endtask

    // One clock: present store data one cycle after the read, then observe.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        bus.msg_rd_data = prev_en ? mem[prev_addr] : 32'hdeadbeef;
        prev_en = bus.msg_rd_en;
        prev_addr = bus.msg_rd_addr;
        if (bus.msg_rd_en) begin
            if (bus.msg_rd_addr != AW'(n_rd) || cyc != 83 * (n_rd / 16) + 1 + n_rd % 16) rd_bad++;
            n_rd++;
        end
        if (bus.core_update) begin
            n_upd++;
            if (cyc != 83 * n_upd) upd_bad++;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
        if (int'(bus.msg_rd_en) + int'(bus.core_init) + int'(bus.core_round_en) + int'(bus.core_update) + int'(done) > 1) viol++;
        if (!bus.core_round_en && (bus.core_wt != '0 || bus.core_round != '0)) viol++;
        if (!bus.msg_rd_en && bus.msg_rd_addr != '0) viol++;
        if (bus.core_round_en && bus.core_round == 6'd16) wt16 = bus.core_wt;
        if (bus.core_round_en && bus.core_round == 6'd17) wt17 = bus.core_wt;
        core_step();
    endtask

    task automatic clear();
        cyc = 0; n_upd = 0; n_done = 0; done_cyc = -1; n_rd = 0; rd_bad = 0;
        upd_bad = 0; busy_cnt = 0; viol = 0; wt16 = '0; wt17 = '0;
        hh = IV;
        v = IV;
    endtask

    task automatic load_mem(input int msel);
        for (int i = 0; i < 64; i++) mem[i] = 32'(i) * 32'h01010101 + 32'h13579bdf;
        if (msel == 0) begin
            for (int i = 0; i < 16; i++) mem[i] = '0;
            mem[0] = 32'h61626380;
            mem[15] = 32'h00000018;
        end else if (msel == 1) begin
            for (int i = 0; i < 14; i++) mem[i] = 32'h61626364 + 32'(i) * 32'h01010101;
            mem[14] = 32'h80000000;
            for (int i = 15; i < 32; i++) mem[i] = '0;
            mem[31] = 32'h000001c0;
        end
    endtask

    task automatic run_vec(input vec_t t, input string tag);
        int budget;
        budget = t.exp_done < 0 ? 200 : t.exp_done + 5;
        clear();
        nblocks = t.nb;
        start = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            start = t.spam && cyc <= t.exp_done;
            if (t.spam) nblocks = 3'd4;
            if (n_done > 0 && cyc >= done_cyc + 2) break;
        end
        start = 1'b0;
        chk_i({tag, "_updates"}, n_upd, t.exp_upd);
        chk_i({tag, "_update_timing_errs"}, upd_bad, 0);
        chk_i({tag, "_done_count"}, n_done, t.exp_done < 0 ? 0 : 1);
        chk_i({tag, "_done_cycle"}, done_cyc, t.exp_done);
        chk_i({tag, "_reads"}, n_rd, t.exp_rd);
        chk_i({tag, "_read_seq_errs"}, rd_bad, 0);
        chk_i({tag, "_busy_cycles"}, busy_cnt, t.exp_done < 0 ? 0 : t.exp_done);
        chk_i({tag, "_protocol_errs"}, viol, 0);
        if (t.chk_dig) chk_v({tag, "_digest"}, {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]}, t.dig);
        if (t.msel == 0 && t.exp_upd > 0) begin
            chk_v({tag, "_wt16"}, 256'(wt16), 256'h61626380);
            chk_v({tag, "_wt17"}, 256'(wt17), 256'h000f0000);
        end
    endtask

    initial begin
        vt[0] = '{3'd1, 0, 1'b0, 1, 84, 16, 1'b1, DIG_ABC};
        vt[1] = '{3'd2, 1, 1'b0, 2, 167, 32, 1'b1, DIG_TWO};
        vt[2] = '{3'd7, 2, 1'b0, 4, 333, 64, 1'b0, '0};
        vt[3] = '{3'd0, 2, 1'b0, 0, -1, 0, 1'b0, '0};
        vt[4] = '{3'd3, 2, 1'b0, 3, 250, 48, 1'b0, '0};
        vt[5] = '{3'd1, 0, 1'b1, 1, 84, 16, 1'b1, DIG_ABC};
        bus.msg_rd_data = '0;
        clear();
        repeat (3) @(posedge clk);
        #1;
        chk_v("reset_outputs", outs(), '0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            load_mem(vt[i].msel);
            run_vec(vt[i], $sformatf("v%0d", i));
        end

        // Abort at round 30 of block 0, then a clean single-block hash.
        load_mem(1);
        clear();
        nblocks = 3'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && !(bus.core_round_en && bus.core_round == 6'd30); i++) tick();
        chk_i("abort_round30_cycle", cyc, 49);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_v("abort_idle_outputs", outs(), '0);
        repeat (150) tick();
        chk_i("abort_no_update", n_upd, 0);
        chk_i("abort_no_done", n_done, 0);
        load_mem(0);
        run_vec(vt[0], "post_abort");

        // Asynchronous reset mid-LOAD and mid-ROUND.
        clear();
        nblocks = 3'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk_i("pre_rst_load_rd_en", int'(bus.msg_rd_en), 1);
        rst_n = 1'b0;
        #2;
        chk_v("rst_mid_load_outputs", outs(), '0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_i("rst_load_stays_idle", int'(busy), 0);
        clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (39) tick();
        chk_i("pre_rst_round_en", int'(bus.core_round_en), 1);
        rst_n = 1'b0;
        #2;
        chk_v("rst_mid_round_outputs", outs(), '0);
        tick();
        rst_n = 1'b1;
        tick();
        run_vec(vt[0], "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
